// File: rtl/gshare_ongorucu.sv
// gshare_ongorucu: gshare direction predictor with branch/JAL target
// computation for an RV32I fetch stage.
//  - Prediction is combinational from the current PHT and speculative GHR.
//  - The speculative GHR shifts at fetch for B-type instructions.
//  - The architectural GHR shifts at resolve.
//  - A mispredict rebuilds the speculative GHR from the architectural one.
// Optional feature: define GSHARE_ISTATISTIK_EN to add the saturating
// update/mispredict counters toplam_o and yanlis_o.
module gshare_ongorucu #(
  parameter int IDX_W = 6,
  parameter int GHR_W = 6,
  parameter int CTR_W = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [31:0]       ps_i,
  input  logic [31:0]       buyruk_i,
  input  logic              getir_gecerli_i,
  output logic [31:0]       atlanan_ps_o,
  output logic              atlanan_gecerli_o,
  output logic [GHR_W-1:0]  tahmin_gg_o,
  input  logic              guncelle_gecerli_i,
  input  logic              guncelle_atladi_i,
  input  logic [31:0]       guncelle_ps_i,
  input  logic [GHR_W-1:0]  guncelle_gg_i,
  input  logic              guncelle_yanlis_i
`ifdef GSHARE_ISTATISTIK_EN
  ,
  output logic [31:0]       toplam_o,
  output logic [31:0]       yanlis_o
`endif
);

  localparam int DEPTH = 1 << IDX_W;
  localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'((1 << (CTR_W - 1)) - 1);
  localparam logic [CTR_W-1:0] CTR_MAX  = {CTR_W{1'b1}};
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  logic [CTR_W-1:0] pht_reg [DEPTH];
  logic [GHR_W-1:0] spec_ghr_reg;
  logic [GHR_W-1:0] spec_ghr_next;
  logic [GHR_W-1:0] arch_ghr_reg;
  logic [GHR_W-1:0] arch_ghr_next;

  logic             is_branch;
  logic             is_jal;
  logic [IDX_W-1:0] pred_idx;
  logic             pht_taken;
  logic [31:0]      imm_b;
  logic [31:0]      imm_j;

  logic [IDX_W-1:0] upd_idx;
  logic [CTR_W-1:0] upd_ctr;
  logic [CTR_W-1:0] upd_ctr_next;

  // Only the index bits of the resolve PC feed the PHT.
  logic unused_ps_bits;
  assign unused_ps_bits = ^{guncelle_ps_i[31:IDX_W+2], guncelle_ps_i[1:0]};

  assign is_branch = (buyruk_i[6:0] == OP_BRANCH);
  assign is_jal    = (buyruk_i[6:0] == OP_JAL);
  assign pred_idx  = ps_i[IDX_W+1:2] ^ IDX_W'(spec_ghr_reg);
  // Read-before-write: the PHT register is read as it stands before this edge.
  assign pht_taken = pht_reg[pred_idx][CTR_W-1];
  assign imm_b = {{19{buyruk_i[31]}}, buyruk_i[31], buyruk_i[7],
                  buyruk_i[30:25], buyruk_i[11:8], 1'b0};
  assign imm_j = {{11{buyruk_i[31]}}, buyruk_i[31], buyruk_i[19:12],
                  buyruk_i[20], buyruk_i[30:21], 1'b0};
  assign tahmin_gg_o = spec_ghr_reg;

  // Combinational prediction; outputs are forced low while reset is held
  // because JAL would otherwise predict taken from an all-reset state.
  always_comb begin
    atlanan_gecerli_o = 1'b0;
    atlanan_ps_o      = 32'd0;
    if (rst_ni) begin
      if (is_jal) begin
        atlanan_gecerli_o = 1'b1;
        atlanan_ps_o      = ps_i + imm_j;
      end else if (is_branch && pht_taken) begin
        atlanan_gecerli_o = 1'b1;
        atlanan_ps_o      = ps_i + imm_b;
      end
    end
  end

  assign upd_idx = guncelle_ps_i[IDX_W+1:2] ^ IDX_W'(guncelle_gg_i);
  assign upd_ctr = pht_reg[upd_idx];

  // Saturating counter step for the entry being resolved.
  always_comb begin
    upd_ctr_next = upd_ctr;
    if (guncelle_atladi_i) begin
      if (upd_ctr != CTR_MAX) upd_ctr_next = upd_ctr + 1'b1;
    end else begin
      if (upd_ctr != '0) upd_ctr_next = upd_ctr - 1'b1;
    end
  end

  // History next-state: fetch shift first, mispredict repair overrides it.
  always_comb begin
    arch_ghr_next = {arch_ghr_reg[GHR_W-2:0], guncelle_atladi_i};
    spec_ghr_next = spec_ghr_reg;
    if (getir_gecerli_i && is_branch)
      spec_ghr_next = {spec_ghr_reg[GHR_W-2:0], pht_taken};
    if (guncelle_gecerli_i && guncelle_yanlis_i)
      spec_ghr_next = arch_ghr_next;
  end

  // History registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      spec_ghr_reg <= '0;
      arch_ghr_reg <= '0;
    end else begin
      spec_ghr_reg <= spec_ghr_next;
      if (guncelle_gecerli_i) arch_ghr_reg <= arch_ghr_next;
    end
  end

  // Pattern history table; every entry resets to weakly not-taken.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) pht_reg[i] <= CTR_INIT;
    end else if (guncelle_gecerli_i) begin
      pht_reg[upd_idx] <= upd_ctr_next;
    end
  end

`ifdef GSHARE_ISTATISTIK_EN
  logic [31:0] toplam_reg;
  logic [31:0] yanlis_reg;

  // Saturating resolve / mispredict counters.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      toplam_reg <= '0;
      yanlis_reg <= '0;
    end else if (guncelle_gecerli_i) begin
      if (toplam_reg != 32'hFFFF_FFFF) toplam_reg <= toplam_reg + 32'd1;
      if (guncelle_yanlis_i && (yanlis_reg != 32'hFFFF_FFFF))
        yanlis_reg <= yanlis_reg + 32'd1;
    end
  end

  assign toplam_o = toplam_reg;
  assign yanlis_o = yanlis_reg;
`endif

endmodule

// File: tb/tb_gshare_ongorucu.sv
// Directed scoreboard bench for gshare_ongorucu (default parameters).
module tb_gshare_ongorucu;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [31:0] ps_i;
  logic [31:0] buyruk_i;
  logic        getir_gecerli_i;
  logic [31:0] atlanan_ps_o;
  logic        atlanan_gecerli_o;
  logic [5:0]  tahmin_gg_o;
  logic        guncelle_gecerli_i;
  logic        guncelle_atladi_i;
  logic [31:0] guncelle_ps_i;
  logic [5:0]  guncelle_gg_i;
  logic        guncelle_yanlis_i;

  localparam logic [31:0] BEQ16  = 32'h0000_0863;
  localparam logic [31:0] JALM8  = 32'hFF9F_F06F;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  typedef struct {
    string       name;
    logic        g;
    logic [31:0] p;
    logic [5:0]  h;
  } exp_t;

  exp_t sb[$];
  event chk_ev;
  int   checks   = 0;
  int   failures = 0;

  gshare_ongorucu dut (
    .clk_i              (clk_i),
    .rst_ni             (rst_ni),
    .ps_i               (ps_i),
    .buyruk_i           (buyruk_i),
    .getir_gecerli_i    (getir_gecerli_i),
    .atlanan_ps_o       (atlanan_ps_o),
    .atlanan_gecerli_o  (atlanan_gecerli_o),
    .tahmin_gg_o        (tahmin_gg_o),
    .guncelle_gecerli_i (guncelle_gecerli_i),
    .guncelle_atladi_i  (guncelle_atladi_i),
    .guncelle_ps_i      (guncelle_ps_i),
    .guncelle_gg_i      (guncelle_gg_i),
    .guncelle_yanlis_i  (guncelle_yanlis_i)
  );

  always #5 clk_i = ~clk_i;

  // Monitor: pops expected entries and compares them with the DUT outputs.
  initial begin
    forever begin
      @(chk_ev);
      while (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        checks++;
        if (atlanan_gecerli_o !== e.g || atlanan_ps_o !== e.p || tahmin_gg_o !== e.h) begin
          failures++;
          $display("FAIL %s: got gec=%0b ps=%08h gg=%02h, want gec=%0b ps=%08h gg=%02h",
                   e.name, atlanan_gecerli_o, atlanan_ps_o, tahmin_gg_o, e.g, e.p, e.h);
        end else begin
          $display("chk %s: gec=%0b ps=%08h gg=%02h", e.name,
                   atlanan_gecerli_o, atlanan_ps_o, tahmin_gg_o);
        end
      end
    end
  end

  // Push one expectation and let the monitor consume it; takes 2 ns.
  task automatic expect_o(input string n, input logic g, input logic [31:0] p,
                          input logic [5:0] h);
    exp_t e;
    #1;
    e.name = n; e.g = g; e.p = p; e.h = h;
    sb.push_back(e);
    ->chk_ev;
    #1;
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL %s_drain: queue size %0d, want 0", n, sb.size());
      sb.delete();
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic idle();
    getir_gecerli_i    = 1'b0;
    guncelle_gecerli_i = 1'b0;
    guncelle_atladi_i  = 1'b0;
    guncelle_ps_i      = 32'd0;
    guncelle_gg_i      = 6'd0;
    guncelle_yanlis_i  = 1'b0;
  endtask

  task automatic upd(input logic [31:0] p, input logic [5:0] gg,
                     input logic tk, input logic yn, input int n);
    guncelle_gecerli_i = 1'b1;
    guncelle_ps_i      = p;
    guncelle_gg_i      = gg;
    guncelle_atladi_i  = tk;
    guncelle_yanlis_i  = yn;
    for (int i = 0; i < n; i++) tick();
    idle();
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni = 1'b0;
    ps_i = 32'd0;
    buyruk_i = NOP;
    idle();
    @(negedge clk_i);
    tick();
    rst_ni = 1'b1;

    // Test 1: reset state
    ps_i = 32'h100; buyruk_i = BEQ16;
    expect_o("t1_reset_beq", 1'b0, 32'h0, 6'h00);

    // Test 2: two taken updates on idx 0; first cycle reads pre-update value
    guncelle_gecerli_i = 1'b1; guncelle_ps_i = 32'h100; guncelle_atladi_i = 1'b1;
    expect_o("t2_read_before_write", 1'b0, 32'h0, 6'h00);
    tick();
    tick();
    idle();
    expect_o("t2_beq_taken", 1'b1, 32'h110, 6'h00);

    // Test 3: JAL target, no history shift on fetch
    ps_i = 32'h200; buyruk_i = JALM8; getir_gecerli_i = 1'b1;
    expect_o("t3_jal", 1'b1, 32'h1F8, 6'h00);
    tick();
    expect_o("t3_jal_gg_hold", 1'b1, 32'h1F8, 6'h00);
    // Fetching a predicted-taken beq shifts a 1 in
    ps_i = 32'h100; buyruk_i = BEQ16;
    expect_o("t3_beq_fetch", 1'b1, 32'h110, 6'h00);
    tick();
    getir_gecerli_i = 1'b0;
    expect_o("t3_beq_shifted", 1'b0, 32'h0, 6'h01);
    // Mispredict flag without update valid is ignored
    guncelle_yanlis_i = 1'b1;
    tick();
    idle();
    expect_o("t3_yanlis_ignored", 1'b0, 32'h0, 6'h01);

    // Test 6: asynchronous reset between edges
    ps_i = 32'h200; buyruk_i = JALM8;
    expect_o("t6_before_reset", 1'b1, 32'h1F8, 6'h01);
    rst_ni = 1'b0;
    expect_o("t6_reset_async", 1'b0, 32'h0, 6'h00);
    tick();
    rst_ni = 1'b1;
    ps_i = 32'h100; buyruk_i = BEQ16;
    expect_o("t6_after_release", 1'b0, 32'h0, 6'h00);

    // Test 4: saturation at 0, then one step up
    ps_i = 32'h0; buyruk_i = BEQ16;
    upd(32'h0, 6'h00, 1'b0, 1'b0, 5);
    expect_o("t4_sat_low", 1'b0, 32'h0, 6'h00);
    upd(32'h0, 6'h00, 1'b1, 1'b0, 1);
    expect_o("t4_after_inc", 1'b0, 32'h0, 6'h00);

    // Test 5: repair wins over fetch shift
    do_reset();
    upd(32'h100, 6'h00, 1'b1, 1'b0, 3);   // 01 -> 11 (saturates)
    upd(32'h100, 6'h00, 1'b0, 1'b0, 1);   // 11 -> 10
    upd(32'h004, 6'h00, 1'b0, 1'b0, 6);   // flush arch GHR to 0 via idx 1
    ps_i = 32'h100; buyruk_i = BEQ16;
    expect_o("t5_sat_high", 1'b1, 32'h110, 6'h00);
    getir_gecerli_i = 1'b1;
    guncelle_gecerli_i = 1'b1; guncelle_ps_i = 32'h100; guncelle_gg_i = 6'h00;
    guncelle_atladi_i = 1'b1; guncelle_yanlis_i = 1'b1;
    tick();
    idle();
    expect_o("t5_repair_gg", 1'b0, 32'h0, 6'h01);   // idx 1 counter is 00
    // Repair with not-taken while fetching a predicted-taken beq
    ps_i = 32'h104; getir_gecerli_i = 1'b1;
    guncelle_gecerli_i = 1'b1; guncelle_ps_i = 32'h100; guncelle_gg_i = 6'h00;
    guncelle_atladi_i = 1'b0; guncelle_yanlis_i = 1'b1;
    expect_o("t5b_pred", 1'b1, 32'h114, 6'h01);
    tick();
    idle();
    ps_i = 32'h108;
    expect_o("t5b_xor_idx0", 1'b1, 32'h118, 6'h02);
    ps_i = 32'h100;
    expect_o("t5b_xor_idx2", 1'b0, 32'h0, 6'h02);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
